iot_event_arbiter: RTL and testbench
====================================

# iot_event_arbiter

Round-robin arbiter that shares the single active-device counter among N IoT gateway requesters. Each gateway posts join (on_off=1) or leave (on_off=0) events over a valid/ready handshake. The arbiter grants at most one event per cycle and drives the counter's change/on_off/rst inputs. It keeps a shadow count so that events which would wrap the counter are rejected rather than applied, and it handles a software clear request.

## Interface
- N, 4: number of requesters, 2..8
- MAX_DEVICES, 200: saturation limit for the count, 1..255
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- clear  input  1  synchronous request to zero the count; overrides all requests
- req_valid  input  N  per-requester event valid
- req_on_off  input  N  per-requester event type: 1=join, 0=leave
- req_ready  output  N  one-hot grant, combinational; an event is consumed when valid&ready
- mon_change  output  1  registered; drives counter change input
- mon_on_off  output  1  registered; drives counter on_off input
- mon_rst  output  1  registered; drives counter synchronous rst input
- count  output  8  registered shadow count of active devices
- reject  output  1  registered one-cycle pulse: the consumed event was refused
- reject_id  output  3  registered index of the refused requester; valid when reject=1
- full  output  1  combinational, count==MAX_DEVICES
- empty  output  1  combinational, count==0

## Operation
- Reset (rst_n=0, async):
  - count=0, rr pointer=0
  - mon_change=0, mon_on_off=0, reject=0, reject_id=0
  - mon_rst=1, so the counter clears during reset. mon_rst drops on the first clk edge after rst_n releases, unless clear=1 at that edge.
- Clear (clear=1 at an edge):
  - req_ready=0 during the cycle; no request is consumed
  - count<=0, mon_rst<=1, mon_change<=0, reject<=0
  - the rr pointer is unchanged
  - mon_rst is high for exactly the cycle(s) following each edge where clear=1
- Arbitration (clear=0):
  - Search req_valid starting at the rr pointer, ascending, modulo N.
  - The first set bit g gets req_ready[g]=1; all other ready bits are 0.
  - If no valid bit is set, req_ready=0 and the pointer is held.
- Effects of a consumed event at edge E:
  - The rr pointer becomes (g+1) mod N, whether the event is applied or rejected.
  - Join with count<MAX_DEVICES (applied): count<=count+1, mon_change<=1, mon_on_off<=1.
  - Leave with count>0 (applied): count<=count-1, mon_change<=1, mon_on_off<=0.
  - Join when full, or leave when empty: the event is still consumed. count is unchanged, mon_change<=0, reject<=1, reject_id<=g.
  - The count never wraps, so the downstream counter never wraps.
- Idle cycle (no consume, no clear): mon_change<=0, mon_rst<=0, reject<=0. mon_on_off holds its previous value.
- Requesters hold req_valid and req_on_off stable until ready. The arbiter does not check this.

## Timing
- Grant is zero-latency: req_ready is a combinational function of req_valid, the pointer, and clear.
- Throughput is one event per cycle, with continuous back-to-back grants.
- Event consumed at edge E:
  - count, mon_change, mon_on_off, reject, and reject_id are valid after E.
  - The counter output changes at E+1, so count leads counter_out by one cycle.
- Clear at edge E: count=0 after E, and counter_out=0 after E+1.
- Fairness: a requester that holds req_valid is granted within N cycles, provided clear stays low.
- When rst_n asserts mid-operation, everything resets immediately. A pending event is lost; the requester must re-present it.

## Test plan
- Reset release with no requests: after the first edge, mon_rst goes 1->0, count=0, empty=1, req_ready=0, and reject never pulses.
- Round-robin fairness: with N=4 and all req_valid=1 with on_off=1 for 8 cycles, grants go 0,1,2,3,0,1,2,3. count goes 0->8, mon_change is high for 8 consecutive cycles, and counter_out=8 one cycle after the final grant.
- Saturation: with MAX_DEVICES=3, present 4 joins from requester 2. The first 3 are applied and count=3 with full=1. The 4th gives reject=1, reject_id=2, mon_change=0, and count stays 3.
- Empty leave: from reset, requester 1 presents a leave. It is consumed with reject=1, reject_id=1, count=0, and the counter is unchanged.
- Clear priority: at count=5, assert clear with req_valid=4'b1111. req_ready=0 that cycle, count=0, mon_rst=1 for one cycle, counter_out=0 one cycle later, and the pointer is unchanged for the next grant.
- Async reset mid-stream: at count=7 during back-to-back grants, pull rst_n low between edges. count=0 and mon_rst=1 immediately. The pointer restarts at 0, so the first post-reset grant goes to the lowest valid requester.

Source files
------------

// File: rtl/iot_event_arbiter.sv
// Round-robin arbiter in front of a shared active-device counter.
// It keeps a shadow count so that the downstream counter never wraps.
module iot_event_arbiter #(
  parameter int N           = 4,
  parameter int MAX_DEVICES = 200
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic [N-1:0] req_valid,
  input  logic [N-1:0] req_on_off,
  output logic [N-1:0] req_ready,
  output logic         mon_change,
  output logic         mon_on_off,
  output logic         mon_rst,
  output logic [7:0]   count,
  output logic         reject,
  output logic [2:0]   reject_id,
  output logic         full,
  output logic         empty
);

  localparam int         PW      = $clog2(N);
  localparam logic [7:0] MAX_CNT = 8'(MAX_DEVICES);

  logic [PW-1:0] r_ptr;
  logic [7:0]    r_count;
  logic          r_mon_change;
  logic          r_mon_on_off;
  logic          r_mon_rst;
  logic          r_reject;
  logic [2:0]    r_reject_id;

  logic [N-1:0]  w_valid_rot;
  logic [N-1:0]  w_onoff_rot;
  logic          w_found;
  logic          w_on_off;
  logic [PW-1:0] w_gnt;
  logic [PW-1:0] w_ptr_next;
  logic          w_at_max;
  logic          w_at_zero;

  // The request vectors are rotated so that bit 0 is the requester at the pointer.
  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_valid_rot = N'({req_valid, req_valid} >> r_ptr);
    w_onoff_rot = N'({req_on_off, req_on_off} >> r_ptr);
    w_found     = 1'b0;
    w_on_off    = 1'b0;
    w_gnt       = '0;
    if (!clear) begin
      for (int k = 0; k < N; k++) begin
        if (!w_found && w_valid_rot[k]) begin
          w_found  = 1'b1;
          w_on_off = w_onoff_rot[k];
          w_gnt    = PW'((int'(r_ptr) + k) % N);
        end
      end
    end
  end

  assign w_ptr_next = (int'(w_gnt) == N - 1) ? '0 : w_gnt + 1'b1;
  assign w_at_max   = (r_count == MAX_CNT);
  assign w_at_zero  = (r_count == 8'd0);

  assign req_ready  = w_found ? (N'(1) << w_gnt) : '0;
  assign full       = w_at_max;
  assign empty      = w_at_zero;
  assign count      = r_count;
  assign mon_change = r_mon_change;
  assign mon_on_off = r_mon_on_off;
  assign mon_rst    = r_mon_rst;
  assign reject     = r_reject;
  assign reject_id  = r_reject_id;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr        <= '0;
      r_count      <= 8'd0;
      r_mon_change <= 1'b0;
      r_mon_on_off <= 1'b0;
      r_mon_rst    <= 1'b1;
      r_reject     <= 1'b0;
      r_reject_id  <= 3'd0;
    end else if (clear) begin
      r_count      <= 8'd0;
      r_mon_rst    <= 1'b1;
      r_mon_change <= 1'b0;
      r_reject     <= 1'b0;
    end else begin
      r_mon_rst    <= 1'b0;
      r_mon_change <= 1'b0;
      r_reject     <= 1'b0;
      if (w_found) begin
        r_ptr <= w_ptr_next;
        // Refused events are still consumed so the requester is not stuck.
        if (w_on_off ? w_at_max : w_at_zero) begin
          r_reject    <= 1'b1;
          r_reject_id <= 3'(w_gnt);
        end else begin
          r_count      <= w_on_off ? r_count + 8'd1 : r_count - 8'd1;
          r_mon_change <= 1'b1;
          r_mon_on_off <= w_on_off;
        end
      end
    end
  end

endmodule

// File: tb/tb_iot_event_arbiter.sv
// Directed bench: instance A (MAX_DEVICES=200) for fairness/clear/reset,
// instance B (MAX_DEVICES=3) for empty-leave and saturation.
module tb_iot_event_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       clear_a, clear_b;
  logic [3:0] valid_a, onoff_a, ready_a;
  logic [3:0] valid_b, onoff_b, ready_b;
  logic       chg_a, oo_a, mrst_a, rej_a, full_a, empty_a;
  logic       chg_b, oo_b, mrst_b, rej_b, full_b, empty_b;
  logic [7:0] cnt_a, cnt_b;
  logic [2:0] rid_a, rid_b;

  // Models of the downstream counters driven by the mon_* outputs.
  logic [7:0] ctr_a, ctr_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  iot_event_arbiter #(.N(4), .MAX_DEVICES(200)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear_a),
    .req_valid(valid_a), .req_on_off(onoff_a), .req_ready(ready_a),
    .mon_change(chg_a), .mon_on_off(oo_a), .mon_rst(mrst_a),
    .count(cnt_a), .reject(rej_a), .reject_id(rid_a),
    .full(full_a), .empty(empty_a)
  );

  iot_event_arbiter #(.N(4), .MAX_DEVICES(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear_b),
    .req_valid(valid_b), .req_on_off(onoff_b), .req_ready(ready_b),
    .mon_change(chg_b), .mon_on_off(oo_b), .mon_rst(mrst_b),
    .count(cnt_b), .reject(rej_b), .reject_id(rid_b),
    .full(full_b), .empty(empty_b)
  );

  always_ff @(posedge clk) begin
    if (mrst_a)     ctr_a <= 8'd0;
    else if (chg_a) ctr_a <= oo_a ? ctr_a + 8'd1 : ctr_a - 8'd1;
    if (mrst_b)     ctr_b <= 8'd0;
    else if (chg_b) ctr_b <= oo_b ? ctr_b + 8'd1 : ctr_b - 8'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    clear_a = 1'b0; valid_a = 4'h0; onoff_a = 4'h0;
    clear_b = 1'b0; valid_b = 4'h0; onoff_b = 4'h0;
    tick();
    tick();

    // Reset state
    check("rst_mon_rst", 32'(mrst_a), 32'd1);
    check("rst_count", 32'(cnt_a), 32'd0);
    check("rst_change", 32'(chg_a), 32'd0);
    check("rst_reject", 32'(rej_a), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_mon_rst_held", 32'(mrst_a), 32'd1);
    tick();
    check("rel_mon_rst_drop", 32'(mrst_a), 32'd0);
    check("rel_count", 32'(cnt_a), 32'd0);
    check("rel_empty", 32'(empty_a), 32'd1);
    check("rel_ready", 32'(ready_a), 32'd0);
    check("rel_reject", 32'(rej_a), 32'd0);

    // Empty leave on B from requester 1
    valid_b = 4'b0010; onoff_b = 4'b0000;
    #1;
    check("eleave_ready", 32'(ready_b), 32'b0010);
    tick();
    valid_b = 4'b0000;
    check("eleave_reject", 32'(rej_b), 32'd1);
    check("eleave_id", 32'(rid_b), 32'd1);
    check("eleave_count", 32'(cnt_b), 32'd0);
    check("eleave_change", 32'(chg_b), 32'd0);
    tick();
    check("eleave_pulse_end", 32'(rej_b), 32'd0);
    check("eleave_counter", 32'(ctr_b), 32'd0);

    // Saturation on B: four joins from requester 2, MAX_DEVICES=3
    valid_b = 4'b0100; onoff_b = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("sat_ready", 32'(ready_b), 32'b0100);
      tick();
      check("sat_count", 32'(cnt_b), 32'(i + 1));
      check("sat_change", 32'(chg_b), 32'd1);
      check("sat_no_reject", 32'(rej_b), 32'd0);
    end
    check("sat_full", 32'(full_b), 32'd1);
    tick();
    valid_b = 4'b0000;
    check("sat4_reject", 32'(rej_b), 32'd1);
    check("sat4_id", 32'(rid_b), 32'd2);
    check("sat4_change", 32'(chg_b), 32'd0);
    check("sat4_count", 32'(cnt_b), 32'd3);
    check("a_idle_no_reject", 32'(rej_a), 32'd0);
    tick();
    check("sat_counter", 32'(ctr_b), 32'd3);

    // Fairness on A: all four join for eight cycles
    valid_a = 4'hF; onoff_a = 4'hF;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("rr_ready", 32'(ready_a), 32'(4'b0001 << (i % 4)));
      tick();
      check("rr_count", 32'(cnt_a), 32'(i + 1));
      check("rr_change", 32'(chg_a), 32'd1);
      check("rr_on_off", 32'(oo_a), 32'd1);
    end
    valid_a = 4'h0;
    tick();
    check("rr_counter_out", 32'(ctr_a), 32'd8);
    check("rr_change_idle", 32'(chg_a), 32'd0);

    // Three leaves from requester 0 bring count to 5; pointer ends at 1
    valid_a = 4'b0001; onoff_a = 4'b0000;
    tick(); tick(); tick();
    check("leave_count", 32'(cnt_a), 32'd5);
    check("leave_on_off", 32'(oo_a), 32'd0);

    // Clear priority
    clear_a = 1'b1; valid_a = 4'hF; onoff_a = 4'hF;
    #1;
    check("clr_ready", 32'(ready_a), 32'd0);
    tick();
    clear_a = 1'b0;
    check("clr_count", 32'(cnt_a), 32'd0);
    check("clr_mon_rst", 32'(mrst_a), 32'd1);
    check("clr_change", 32'(chg_a), 32'd0);
    #1;
    check("clr_ptr_kept", 32'(ready_a), 32'b0010);
    tick();
    check("clr_mon_rst_drop", 32'(mrst_a), 32'd0);
    check("clr_counter_out", 32'(ctr_a), 32'd0);
    check("clr_next_count", 32'(cnt_a), 32'd1);

    // Back-to-back grants 2,3,0,1,2 then requester 1: count 7, pointer 2
    repeat (5) tick();
    valid_a = 4'b0010;
    tick();
    check("pre_rst_count", 32'(cnt_a), 32'd7);

    // Async reset between edges
    rst_n = 1'b0;
    #1;
    check("arst_count", 32'(cnt_a), 32'd0);
    check("arst_mon_rst", 32'(mrst_a), 32'd1);
    check("arst_change", 32'(chg_a), 32'd0);
    valid_a = 4'b0110;
    #1;
    rst_n = 1'b1;
    #1;
    check("arst_ptr_zero", 32'(ready_a), 32'b0010);
    tick();
    check("arst_count_after", 32'(cnt_a), 32'd1);
    check("arst_change_after", 32'(chg_a), 32'd1);
    valid_a = 4'h0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
